// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS core pipe registers.
//   state_t          : data-memory handshake state (IDLE, BUSY)
//   MEMTOREG_*       : writeback source select encodings
//   REG_IDX_W        : MIPS register-index width
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/acknowledge sequencer for the execute/memory stage.
// Issues one access per 'issue' pulse seen in IDLE, waits in BUSY for mem_ack
// and forces completion after TIMEOUT BUSY edges without an ack.
// Ports:
//   clk, reset          : falling-edge clock, async active-low reset
//   issue               : start an access this edge (only honoured in IDLE)
//   is_store, addr,
//   wdata               : access description latched on issue
//   mem_ack             : memory completion, sampled only in BUSY
//   mem_req, mem_we,
//   mem_addr, mem_wdata : registered memory request
//   stall               : high while an access is outstanding
//   complete            : this edge ends the access (ack or timeout)
//   timed_out           : this edge ends the access by timeout
//   mem_error           : sticky timeout flag
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        complete,
  output logic        timed_out,
  output logic        mem_error
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          at_limit;

  // The counter stops at LAST because reaching it always ends the access.
  assign at_limit  = (count == LAST);
  assign stall     = (state == BUSY);
  assign complete  = (state == BUSY) && (mem_ack || at_limit);
  assign timed_out = (state == BUSY) && !mem_ack && at_limit;

  // Handshake FSM with its registered request outputs and timeout counter.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= BUSY;
            count     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end
        end
        BUSY: begin
          if (mem_ack || at_limit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_ack) begin
              mem_error <= 1'b1;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_execute_memory.sv
// Execute/memory pipeline register. Captures execute-stage result and control
// on the falling edge, runs loads/stores through dmem_handshake while holding
// the upstream stages, and presents a valid memory-stage bundle to writeback.
// Ports:
//   clk, reset              : falling-edge clock, async active-low reset
//   *_E                     : execute-stage bundle (Valid_E, Flush_E, control, data)
//   mem_req/we/addr/wdata   : data-memory request
//   mem_ack, mem_rdata      : data-memory response
//   *_M                     : memory-stage bundle
//   Stall_M                 : hold PC, fetch/decode and decode/execute registers
//   mem_error               : sticky access-timeout flag
module pipe_execute_memory
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Valid_E,
  input  logic                 Flush_E,
  input  logic                 RegWrite_E,
  input  logic                 MemRead_E,
  input  logic                 MemWrite_E,
  input  logic [1:0]           MemToReg_E,
  input  logic [31:0]          ALUResult_E,
  input  logic [31:0]          WriteData_E,
  input  logic [REG_IDX_W-1:0] WriteReg_E,
  input  logic [31:0]          PC_4_E,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 Valid_M,
  output logic                 RegWrite_M,
  output logic [1:0]           MemToReg_M,
  output logic [31:0]          ALUResult_M,
  output logic [31:0]          ReadData_M,
  output logic [31:0]          PC_4_M,
  output logic [REG_IDX_W-1:0] WriteReg_M,
  output logic                 Stall_M,
  output logic                 mem_error
);

  logic take;
  logic is_mem;
  logic issue;
  logic complete;
  logic timed_out;

  assign take   = Valid_E && !Flush_E;
  assign is_mem = MemRead_E || MemWrite_E;
  assign issue  = take && is_mem;

  // MemWrite_E alone decides direction, so read+write together is a store.
  dmem_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_dmem_handshake (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .is_store  (MemWrite_E),
    .addr      (ALUResult_E),
    .wdata     (WriteData_E),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (Stall_M),
    .complete  (complete),
    .timed_out (timed_out),
    .mem_error (mem_error)
  );

  // Memory-stage registers: load from E when idle, finish the bundle on completion.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      Valid_M     <= 1'b0;
      RegWrite_M  <= 1'b0;
      MemToReg_M  <= 2'd0;
      ALUResult_M <= 32'h0000_0000;
      ReadData_M  <= 32'h0000_0000;
      PC_4_M      <= 32'h0000_0000;
      WriteReg_M  <= '0;
    end else if (!Stall_M) begin
      // A memory op is captured invalid; it becomes valid when the access ends.
      Valid_M     <= take && !is_mem;
      RegWrite_M  <= take && RegWrite_E;
      MemToReg_M  <= MemToReg_E;
      ALUResult_M <= ALUResult_E;
      PC_4_M      <= PC_4_E;
      WriteReg_M  <= WriteReg_E;
    end else if (complete) begin
      Valid_M <= 1'b1;
      if (timed_out) begin
        ReadData_M <= 32'h0000_0000;
      end else if (!mem_we) begin
        ReadData_M <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pipe_execute_memory.sv
module tb_pipe_execute_memory;
  import pipe_pkg::*;

  localparam int TO = 16;

  logic        clk, reset;
  logic        Valid_E, Flush_E, RegWrite_E, MemRead_E, MemWrite_E;
  logic [1:0]  MemToReg_E;
  logic [31:0] ALUResult_E, WriteData_E, PC_4_E;
  logic [4:0]  WriteReg_E;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        Valid_M, RegWrite_M, Stall_M, mem_error;
  logic [1:0]  MemToReg_M;
  logic [31:0] ALUResult_M, ReadData_M, PC_4_M;
  logic [4:0]  WriteReg_M;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: transaction-level view of the stage.
  bit          m_busy;
  int          waited;
  logic        e_req, e_we, e_valid, e_rw, e_err;
  logic [31:0] e_addr, e_wdata, e_alu, e_rd, e_pc4;
  logic [1:0]  e_m2r;
  logic [4:0]  e_wr;

  pipe_execute_memory #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Valid_E(Valid_E), .Flush_E(Flush_E), .RegWrite_E(RegWrite_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .MemToReg_E(MemToReg_E),
    .ALUResult_E(ALUResult_E), .WriteData_E(WriteData_E), .WriteReg_E(WriteReg_E),
    .PC_4_E(PC_4_E),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .MemToReg_M(MemToReg_M),
    .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M), .PC_4_M(PC_4_M),
    .WriteReg_M(WriteReg_M), .Stall_M(Stall_M), .mem_error(mem_error)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; waited = 0;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_valid = 1'b0; e_rw = 1'b0; e_m2r = '0; e_alu = '0; e_rd = '0;
    e_pc4 = '0; e_wr = '0; e_err = 1'b0;
  endtask

  // Advance the model by one falling edge using the inputs now applied.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (!m_busy) begin
      e_valid = Valid_E && !Flush_E;
      e_rw    = e_valid && RegWrite_E;
      e_m2r = MemToReg_E; e_alu = ALUResult_E; e_pc4 = PC_4_E; e_wr = WriteReg_E;
      if (e_valid && (MemRead_E || MemWrite_E)) begin
        m_busy = 1'b1; waited = 0; e_valid = 1'b0;
        e_req = 1'b1; e_we = MemWrite_E; e_addr = ALUResult_E; e_wdata = WriteData_E;
      end
    end else begin
      waited++;
      if (mem_ack || waited == TO) begin
        m_busy = 1'b0; e_req = 1'b0; e_valid = 1'b1;
        if (!mem_ack) begin
          e_rd = 32'h0; e_err = 1'b1;
        end else if (!e_we) begin
          e_rd = mem_rdata;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Compare every DUT output against the model on the non-active edge.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("cmp_mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("cmp_mem_we", {31'd0, mem_we}, {31'd0, e_we});
      chk("cmp_mem_addr", mem_addr, e_addr);
      chk("cmp_mem_wdata", mem_wdata, e_wdata);
      chk("cmp_valid", {31'd0, Valid_M}, {31'd0, e_valid});
      chk("cmp_regwrite", {31'd0, RegWrite_M}, {31'd0, e_rw});
      chk("cmp_stall", {31'd0, Stall_M}, {31'd0, m_busy});
      chk("cmp_mem_error", {31'd0, mem_error}, {31'd0, e_err});
      if (e_valid) begin
        chk("cmp_memtoreg", {30'd0, MemToReg_M}, {30'd0, e_m2r});
        chk("cmp_alu", ALUResult_M, e_alu);
        chk("cmp_rdata", ReadData_M, e_rd);
        chk("cmp_pc4", PC_4_M, e_pc4);
        chk("cmp_wreg", {27'd0, WriteReg_M}, {27'd0, e_wr});
      end
    end
  end

  task automatic set_e(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] m2r, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr, input logic [31:0] pc4);
    Valid_E = v; Flush_E = 1'b0; RegWrite_E = rw; MemRead_E = mr; MemWrite_E = mw;
    MemToReg_E = m2r; ALUResult_E = alu; WriteData_E = wd; WriteReg_E = wr; PC_4_E = pc4;
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    set_e(1'b0, 1'b0, 1'b0, 1'b0, MEMTOREG_ALU, 32'h0, 32'h0, 5'd0, 32'h0);
    model_reset();
    cyc(); cyc();
    // Reset state
    chk("rst_valid", {31'd0, Valid_M}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, Stall_M}, 32'd0);
    chk("rst_alu", ALUResult_M, 32'd0);
    chk("rst_err", {31'd0, mem_error}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    cyc();

    // ALU op, then a back-to-back jal-style op
    set_e(1'b1, 1'b1, 1'b0, 1'b0, MEMTOREG_ALU, 32'h0000_0010, 32'h0, 5'd8, 32'h0000_0104);
    cyc();
    chk("alu_result", ALUResult_M, 32'h10);
    chk("alu_wreg", {27'd0, WriteReg_M}, 32'd8);
    chk("alu_valid", {31'd0, Valid_M}, 32'd1);
    chk("alu_stall", {31'd0, Stall_M}, 32'd0);
    set_e(1'b1, 1'b1, 1'b0, 1'b0, MEMTOREG_PC4, 32'hAAAA_5555, 32'h0, 5'd31, 32'h0000_0200);
    cyc();
    chk("jal_pc4", PC_4_M, 32'h200);
    chk("jal_m2r", {30'd0, MemToReg_M}, {30'd0, MEMTOREG_PC4});

    // Flushed store in IDLE becomes a bubble with no request
    set_e(1'b1, 1'b0, 1'b0, 1'b1, MEMTOREG_ALU, 32'h0000_0050, 32'h9999, 5'd0, 32'h0);
    Flush_E = 1'b1;
    cyc();
    chk("flush_req", {31'd0, mem_req}, 32'd0);
    chk("flush_valid", {31'd0, Valid_M}, 32'd0);
    chk("flush_stall", {31'd0, Stall_M}, 32'd0);

    // Load at 0x40, ack on the third BUSY edge
    set_e(1'b1, 1'b1, 1'b1, 1'b0, MEMTOREG_MEM, 32'h0000_0040, 32'h0, 5'd9, 32'h0000_0300);
    cyc();
    chk("ld_req", {31'd0, mem_req}, 32'd1);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_addr", mem_addr, 32'h40);
    for (int i = 0; i < 2; i++) begin
      chk("ld_stall", {31'd0, Stall_M}, 32'd1);
      cyc();
    end
    chk("ld_stall3", {31'd0, Stall_M}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_rdata", ReadData_M, 32'hDEAD_BEEF);
    chk("ld_valid", {31'd0, Valid_M}, 32'd1);
    chk("ld_stall_end", {31'd0, Stall_M}, 32'd0);

    // Store at 0x44 with a flush pulse while BUSY
    set_e(1'b1, 1'b0, 1'b0, 1'b1, MEMTOREG_ALU, 32'h0000_0044, 32'h0000_1234, 5'd0, 32'h0);
    cyc();
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, 32'h44);
    chk("st_wdata", mem_wdata, 32'h1234);
    Flush_E = 1'b1;
    cyc();
    Flush_E = 1'b0;
    chk("st_flush_ignored", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    cyc();
    mem_ack = 1'b0;
    chk("st_valid", {31'd0, Valid_M}, 32'd1);
    chk("st_regwrite", {31'd0, RegWrite_M}, 32'd0);
    chk("st_rdata_kept", ReadData_M, 32'hDEAD_BEEF);

    // Read+write together is a store; ack on first BUSY edge
    set_e(1'b1, 1'b0, 1'b1, 1'b1, MEMTOREG_ALU, 32'h0000_0048, 32'h0000_00AB, 5'd0, 32'h0);
    cyc();
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_valid_early", {31'd0, Valid_M}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    cyc();
    chk("rw_valid", {31'd0, Valid_M}, 32'd1);
    chk("rw_rdata_kept", ReadData_M, 32'hDEAD_BEEF);

    // Ack while IDLE is ignored
    set_e(1'b0, 1'b0, 1'b0, 1'b0, MEMTOREG_ALU, 32'h0, 32'h0, 5'd0, 32'h0);
    mem_rdata = 32'h2222_2222;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_stall", {31'd0, Stall_M}, 32'd0);

    // Load never acked: forced completion after TO BUSY edges
    set_e(1'b1, 1'b1, 1'b1, 1'b0, MEMTOREG_MEM, 32'h0000_0080, 32'h0, 5'd10, 32'h0);
    cyc();
    for (int i = 0; i < TO - 1; i++) cyc();
    chk("to_stall_before", {31'd0, Stall_M}, 32'd1);
    chk("to_err_before", {31'd0, mem_error}, 32'd0);
    cyc();
    chk("to_stall", {31'd0, Stall_M}, 32'd0);
    chk("to_valid", {31'd0, Valid_M}, 32'd1);
    chk("to_rdata", ReadData_M, 32'h0);
    chk("to_err", {31'd0, mem_error}, 32'd1);
    chk("to_regwrite", {31'd0, RegWrite_M}, 32'd1);
    set_e(1'b1, 1'b1, 1'b0, 1'b0, MEMTOREG_ALU, 32'h0000_0777, 32'h0, 5'd3, 32'h0);
    cyc(); cyc();
    chk("err_sticky", {31'd0, mem_error}, 32'd1);

    // Reset in the middle of BUSY
    set_e(1'b1, 1'b1, 1'b1, 1'b0, MEMTOREG_MEM, 32'h0000_00C0, 32'h0, 5'd4, 32'h0);
    cyc(); cyc();
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, Stall_M}, 32'd0);
    chk("mid_rst_valid", {31'd0, Valid_M}, 32'd0);
    chk("mid_rst_err", {31'd0, mem_error}, 32'd0);
    cyc();
    reset = 1'b1;
    set_e(1'b1, 1'b1, 1'b0, 1'b0, MEMTOREG_ALU, 32'h0000_0123, 32'h0, 5'd5, 32'h0);
    cyc();
    chk("post_rst_valid", {31'd0, Valid_M}, 32'd1);
    chk("post_rst_alu", ALUResult_M, 32'h123);
    chk("post_rst_stall", {31'd0, Stall_M}, 32'd0);
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
